// File: rtl/act_fun_scheduler_if.sv
// Bundle for act_fun_scheduler: requester side, activation engine side and response side.
// The scheduler connects to the slave modport; requesters and the engine sit on master.
interface act_fun_scheduler_if #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned ID_WIDTH = 2,
  parameter int unsigned WIDTH    = 16
);
  logic [NUM_REQ-1:0]       REQ_VALID;
  logic [NUM_REQ*WIDTH-1:0] REQ_VALUE;
  logic [NUM_REQ-1:0]       REQ_READY;
  logic [WIDTH-1:0]         ACT_VALUE_OUT;
  logic                     ACT_VALID_OUT;
  logic [WIDTH-1:0]         ACT_VALUE_IN;
  logic                     ACT_VALID_IN;
  logic                     ACT_OVERFLOW_IN;
  logic                     RSP_VALID;
  logic [ID_WIDTH-1:0]      RSP_ID;
  logic [WIDTH-1:0]         RSP_VALUE;
  logic                     RSP_OVERFLOW;
  logic                     RSP_TIMEOUT;
  logic                     BUSY;

  modport slave (
    input  REQ_VALID, REQ_VALUE, ACT_VALUE_IN, ACT_VALID_IN, ACT_OVERFLOW_IN,
    output REQ_READY, ACT_VALUE_OUT, ACT_VALID_OUT,
    output RSP_VALID, RSP_ID, RSP_VALUE, RSP_OVERFLOW, RSP_TIMEOUT, BUSY
  );

  modport master (
    output REQ_VALID, REQ_VALUE, ACT_VALUE_IN, ACT_VALID_IN, ACT_OVERFLOW_IN,
    input  REQ_READY, ACT_VALUE_OUT, ACT_VALID_OUT,
    input  RSP_VALID, RSP_ID, RSP_VALUE, RSP_OVERFLOW, RSP_TIMEOUT, BUSY
  );
endinterface

// File: rtl/act_fun_scheduler.sv
// Round-robin scheduler sharing one tanh activation engine among NUM_REQ requesters,
// with a single operation in flight and a watchdog on the engine response.
module act_fun_scheduler #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned ID_WIDTH       = 2,
  parameter int unsigned WIDTH          = 16,
  parameter int unsigned FRAC_BITS      = 13,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input logic                 CLK,
  input logic                 RSTN,
  act_fun_scheduler_if.slave  bus
);

  localparam int unsigned    CntW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES);

  if ((1 << ID_WIDTH) < NUM_REQ) begin : g_bad_id_width
    $error("ID_WIDTH too narrow for NUM_REQ");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end
  if (FRAC_BITS >= WIDTH) begin : g_bad_frac
    $error("FRAC_BITS must be below WIDTH");
  end

  typedef enum logic [2:0] {StIdle, StIssue, StWait, StSettle, StRespond} state_e;

  state_e              r_state, w_state_nxt;
  logic [ID_WIDTH-1:0] r_ptr, r_id, w_grant_id, w_ptr_nxt, w_idx;
  logic                w_grant_vld, w_accept, w_timeout;
  logic [CntW-1:0]     r_cnt;
  logic [WIDTH-1:0]    r_result;
  logic [WIDTH-1:0]    w_ops [NUM_REQ];

  logic                r_act_valid;
  logic [WIDTH-1:0]    r_act_value;
  logic                r_rsp_valid;
  logic [ID_WIDTH-1:0] r_rsp_id;
  logic [WIDTH-1:0]    r_rsp_value;
  logic                r_rsp_ovf;
  logic                r_rsp_timeout;
  logic                r_busy;

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_ops[i] = bus.REQ_VALUE[i*WIDTH +: WIDTH];
    end
  end

  // First valid requester at or above the pointer, wrapping modulo NUM_REQ.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_id  = '0;
    w_idx       = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_idx = ID_WIDTH'((32'(r_ptr) + k) % NUM_REQ);
      if (!w_grant_vld && bus.REQ_VALID[w_idx]) begin
        w_grant_vld = 1'b1;
        w_grant_id  = w_idx;
      end
    end
  end

  assign w_accept  = (r_state == StIdle) && w_grant_vld;
  assign w_ptr_nxt = (w_grant_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : w_grant_id + 1'b1;
  // An engine result in the terminal cycle wins over the watchdog.
  assign w_timeout = (r_state == StWait) && !bus.ACT_VALID_IN && (r_cnt == CntMax);

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) r_state <= StIdle;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:    if (w_grant_vld) w_state_nxt = StIssue;
      StIssue:   w_state_nxt = StWait;
      StWait: begin
        if (bus.ACT_VALID_IN) w_state_nxt = StSettle;
        else if (w_timeout)   w_state_nxt = StRespond;
      end
      StSettle:  w_state_nxt = StRespond;
      StRespond: w_state_nxt = StIdle;
      default:   w_state_nxt = StIdle;
    endcase
  end

  always_comb begin
    bus.REQ_READY = '0;
    if (r_state == StIdle && w_grant_vld) bus.REQ_READY[w_grant_id] = 1'b1;
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_ptr         <= '0;
      r_id          <= '0;
      r_cnt         <= '0;
      r_result      <= '0;
      r_act_valid   <= 1'b0;
      r_act_value   <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_id      <= '0;
      r_rsp_value   <= '0;
      r_rsp_ovf     <= 1'b0;
      r_rsp_timeout <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_act_valid <= w_accept;
      r_act_value <= w_accept ? w_ops[w_grant_id] : '0;
      r_busy      <= (w_state_nxt != StIdle);
      if (w_accept) begin
        r_ptr <= w_ptr_nxt;
        r_id  <= w_grant_id;
      end
      if (r_state == StIssue) begin
        r_cnt <= '0;
      end else if (r_state == StWait && !bus.ACT_VALID_IN && r_cnt != CntMax) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (r_state == StWait && bus.ACT_VALID_IN) r_result <= bus.ACT_VALUE_IN;

      r_rsp_valid   <= 1'b0;
      r_rsp_id      <= '0;
      r_rsp_value   <= '0;
      r_rsp_ovf     <= 1'b0;
      r_rsp_timeout <= 1'b0;
      // Overflow lags the engine result by a cycle, so it is sampled on leaving SETTLE.
      if (r_state == StSettle) begin
        r_rsp_valid <= 1'b1;
        r_rsp_id    <= r_id;
        r_rsp_value <= r_result;
        r_rsp_ovf   <= bus.ACT_OVERFLOW_IN;
      end else if (w_timeout) begin
        r_rsp_valid   <= 1'b1;
        r_rsp_id      <= r_id;
        r_rsp_timeout <= 1'b1;
      end
    end
  end

  assign bus.ACT_VALID_OUT = r_act_valid;
  assign bus.ACT_VALUE_OUT = r_act_value;
  assign bus.RSP_VALID     = r_rsp_valid;
  assign bus.RSP_ID        = r_rsp_id;
  assign bus.RSP_VALUE     = r_rsp_value;
  assign bus.RSP_OVERFLOW  = r_rsp_ovf;
  assign bus.RSP_TIMEOUT   = r_rsp_timeout;
  assign bus.BUSY          = r_busy;

endmodule

// File: tb/tb_act_fun_scheduler.sv
// Self-checking bench for act_fun_scheduler with a behavioural tanh engine stub and
// an operation-level reference model (grant order, latency, result, overflow, timeout).
module tb_act_fun_scheduler;

  localparam int T = 16;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  act_fun_scheduler_if #(.NUM_REQ(4), .ID_WIDTH(2), .WIDTH(16)) bus ();

  act_fun_scheduler #(
    .NUM_REQ(4), .ID_WIDTH(2), .WIDTH(16), .FRAC_BITS(13), .TIMEOUT_CYCLES(T)
  ) dut (
    .CLK (clk),
    .RSTN(rstn),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int m_ptr = 0;

  logic [3:0]         req_valid = '0;
  logic signed [15:0] req_val [4];
  assign bus.REQ_VALID = req_valid;
  always_comb begin
    for (int i = 0; i < 4; i++) bus.REQ_VALUE[i*16 +: 16] = req_val[i];
  end

  // ---------------- engine stub ----------------
  int                 stub_lat = 3;  // 0 means the engine never answers
  int                 st_cnt = 0;
  logic signed [15:0] st_op = '0;
  logic               eng_valid = 1'b0;
  logic [15:0]        eng_value = '0;
  logic               eng_ovf = 1'b0;
  logic               eng_ovf_pend = 1'b0;
  assign bus.ACT_VALID_IN    = eng_valid;
  assign bus.ACT_VALUE_IN    = eng_value;
  assign bus.ACT_OVERFLOW_IN = eng_ovf;

  function automatic logic [15:0] tanh_fx(input logic signed [15:0] x);
    real r, e, t;
    int  q;
    r = $itor(x) / 8192.0;
    e = $exp(2.0 * r);
    t = (e - 1.0) / (e + 1.0);
    q = $rtoi(t * 8192.0 + ((t >= 0.0) ? 0.5 : -0.5));
    return 16'(q);
  endfunction

  function automatic logic ovf_rule(input logic signed [15:0] x);
    return (x >= 16'sh6000) || (x <= -16'sh6000);
  endfunction

  always @(posedge clk) begin
    eng_valid <= 1'b0;
    if (eng_ovf_pend) begin
      eng_ovf      <= 1'b1;
      eng_ovf_pend <= 1'b0;
    end
    if (bus.ACT_VALID_OUT) begin
      st_cnt  <= stub_lat;
      st_op   <= bus.ACT_VALUE_OUT;
      eng_ovf <= 1'b0;
    end else if (st_cnt > 0) begin
      st_cnt <= st_cnt - 1;
      if (st_cnt == 1) begin
        eng_valid    <= 1'b1;
        eng_value    <= tanh_fx(st_op);
        eng_ovf_pend <= ovf_rule(st_op);
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic int model_grant(input logic [3:0] mask, input int ptr);
    for (int k = 0; k < 4; k++) begin
      if (mask[(ptr + k) % 4]) return (ptr + k) % 4;
    end
    return 0;
  endfunction

  // One complete operation: request, grant, issue, response; returns granted id.
  task automatic run_op(input logic [3:0] mask, input bit hold, input int lat, output int gid);
    int          eg, exp_n;
    bit          got, et, eo;
    logic [3:0]  exp_oh;
    logic [1:0]  eid;
    logic [15:0] op, ev;
    @(negedge clk);
    req_valid = mask;
    stub_lat  = lat;
    #1;
    eg     = model_grant(mask, m_ptr);
    exp_oh = 4'b0001 << eg;
    eid    = 2'(eg);
    n_vec++;
    if (bus.REQ_READY !== exp_oh) begin
      n_err++;
      $display("FAIL grant: REQ_READY=%b expected %b", bus.REQ_READY, exp_oh);
    end
    gid   = eg;
    m_ptr = (eg + 1) % 4;
    op    = req_val[eg];
    et    = (lat == 0) || (lat > T);
    ev    = et ? 16'h0 : tanh_fx(op);
    eo    = et ? 1'b0 : ovf_rule(op);
    exp_n = et ? T + 2 : lat + 3;
    @(posedge clk);
    got = 0;
    for (int n = 0; n <= T + 8 && !got; n++) begin
      @(negedge clk);
      if (n == 0 && !hold) req_valid[eg] = 1'b0;
      n_vec++;
      if (bus.REQ_READY !== 4'b0) begin
        n_err++;
        $display("FAIL ready_busy: REQ_READY=%b expected 0000 at n=%0d", bus.REQ_READY, n);
      end
      if (n == 0) begin
        n_vec++;
        if (bus.ACT_VALID_OUT !== 1'b1 || bus.ACT_VALUE_OUT !== op || bus.BUSY !== 1'b1) begin
          n_err++;
          $display("FAIL issue: valid=%b value=%h busy=%b expected 1 %h 1",
                   bus.ACT_VALID_OUT, bus.ACT_VALUE_OUT, bus.BUSY, op);
        end
      end else begin
        n_vec++;
        if (bus.ACT_VALID_OUT !== 1'b0) begin
          n_err++;
          $display("FAIL issue_pulse: ACT_VALID_OUT=%b expected 0 at n=%0d", bus.ACT_VALID_OUT, n);
        end
      end
      if (bus.RSP_VALID === 1'b1) begin
        got = 1;
        n_vec++;
        if (n !== exp_n) begin
          n_err++;
          $display("FAIL latency: response at %0d expected %0d", n, exp_n);
        end
        n_vec++;
        if (bus.RSP_ID !== eid) begin
          n_err++;
          $display("FAIL rsp_id: got %0d expected %0d", bus.RSP_ID, eid);
        end
        n_vec++;
        if (bus.RSP_VALUE !== ev) begin
          n_err++;
          $display("FAIL rsp_value: got %h expected %h", bus.RSP_VALUE, ev);
        end
        n_vec++;
        if (bus.RSP_OVERFLOW !== eo) begin
          n_err++;
          $display("FAIL rsp_overflow: got %b expected %b", bus.RSP_OVERFLOW, eo);
        end
        n_vec++;
        if (bus.RSP_TIMEOUT !== et) begin
          n_err++;
          $display("FAIL rsp_timeout: got %b expected %b", bus.RSP_TIMEOUT, et);
        end
      end
    end
    if (!got) begin
      n_vec++;
      n_err++;
      $display("FAIL no_response: RSP_VALID=0 expected 1 within %0d cycles", T + 8);
    end
  endtask

  task automatic check_idle_quiet(input int cycles, input string tag);
    for (int n = 0; n < cycles; n++) begin
      @(negedge clk);
      n_vec++;
      if (bus.RSP_VALID !== 1'b0 || bus.BUSY !== 1'b0) begin
        n_err++;
        $display("FAIL %s: RSP_VALID=%b BUSY=%b expected 0 0", tag, bus.RSP_VALID, bus.BUSY);
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    for (int i = 0; i < 4; i++) req_val[i] = 16'(16'h0100 * (i + 1));
    repeat (2) @(negedge clk);
    n_vec++;
    if ({bus.ACT_VALID_OUT, bus.ACT_VALUE_OUT, bus.RSP_VALID, bus.RSP_ID, bus.RSP_VALUE,
         bus.RSP_OVERFLOW, bus.RSP_TIMEOUT, bus.BUSY, bus.REQ_READY} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: some output nonzero (busy=%b rsp_valid=%b) expected 0",
               bus.BUSY, bus.RSP_VALID);
    end
    rstn = 1'b1;
    m_ptr = 0;
  endtask

  task automatic test_round_robin();
    int g;
    for (int i = 0; i < 5; i++) run_op(4'b1111, 1'b1, 3, g);
    run_op(4'b0101, 1'b0, 2, g);
    req_valid = '0;
  endtask

  task automatic test_single();
    int g;
    req_val[1] = 16'sh2000;
    run_op(4'b0010, 1'b0, 3, g);
  endtask

  task automatic test_overflow();
    int g;
    req_val[3] = 16'sh7000;
    req_val[0] = 16'sh1000;
    run_op(4'b1000, 1'b0, 3, g);
    run_op(4'b0001, 1'b0, 3, g);
  endtask

  task automatic test_timeout();
    int g;
    req_val[2] = 16'shE000;
    run_op(4'b0100, 1'b0, T + 5, g);
    check_idle_quiet(8, "late_result");
    run_op(4'b0100, 1'b0, 0, g);
  endtask

  task automatic test_simultaneous();
    int g;
    req_val[1] = 16'sh0800;
    req_val[3] = 16'shF000;
    run_op(4'b0010, 1'b0, T, g);
    run_op(4'b1000, 1'b0, T + 1, g);
  endtask

  task automatic test_reset_mid_wait();
    int g;
    @(negedge clk);
    req_val[2] = 16'sh0ABC;
    req_valid  = 4'b0100;
    stub_lat   = 12;
    @(negedge clk);
    req_valid = '0;
    repeat (3) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    n_vec++;
    if ({bus.ACT_VALID_OUT, bus.ACT_VALUE_OUT, bus.RSP_VALID, bus.RSP_ID, bus.RSP_VALUE,
         bus.RSP_OVERFLOW, bus.RSP_TIMEOUT} !== '0) begin
      n_err++;
      $display("FAIL async_reset_outputs: some output nonzero (rsp_valid=%b) expected 0",
               bus.RSP_VALID);
    end
    n_vec++;
    if (bus.BUSY !== 1'b0 || bus.REQ_READY !== 4'b0) begin
      n_err++;
      $display("FAIL async_reset_busy: BUSY=%b REQ_READY=%b expected 0 0000",
               bus.BUSY, bus.REQ_READY);
    end
    m_ptr = 0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    check_idle_quiet(14, "stale_response");
    run_op(4'b1111, 1'b0, 2, g);
  endtask

  task automatic test_random();
    int         g;
    logic [3:0] mask;
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < 4; i++) req_val[i] = 16'($urandom);
      mask = 4'($urandom_range(1, 15));
      run_op(mask, 1'b0, $urandom_range(1, T + 3), g);
      req_valid = '0;
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_overflow();
    test_timeout();
    test_simultaneous();
    test_reset_mid_wait();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
